// File: rtl/assembly_line_ctrl_if.sv
// Entry handshake, line controls and status outputs of the assembly-line conveyor controller.
// Handshake: a piece moves at a rising edge where piece_in=1 and piece_rdy=1. piece_rdy depends
// only on controller state, never on piece_in. The master may drop piece_in at any time.
interface assembly_line_ctrl_if #(
  parameter int STAGES = 4,
  parameter int CNT_W  = 8
);
  logic              piece_in;
  logic              piece_rdy;
  logic              halt;
  logic              qc_ok;
  logic              z;
  logic              reject;
  logic [STAGES-1:0] occupancy;
  logic [CNT_W-1:0]  good_count;
  logic [CNT_W-1:0]  reject_count;

  modport master (
    output piece_in, halt, qc_ok,
    input  piece_rdy, z, reject, occupancy, good_count, reject_count
  );

  modport slave (
    input  piece_in, halt, qc_ok,
    output piece_rdy, z, reject, occupancy, good_count, reject_count
  );
endinterface

// File: rtl/assembly_line_ctrl.sv
// Conveyor controller: a one-deep entry buffer feeds a STAGES-station belt that advances
// every WORK_CYCLES clocks. Exits are graded by qc_ok and tallied in saturating counters.
module assembly_line_ctrl #(
  parameter int STAGES      = 4,
  parameter int WORK_CYCLES = 3,
  parameter int CNT_W       = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  assembly_line_ctrl_if.slave  bus,
  output logic [1:0]           state
);
  localparam int CW = (WORK_CYCLES > 1) ? $clog2(WORK_CYCLES) : 1;
  localparam logic [CW-1:0]    LAST    = CW'(WORK_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WORK = 2'd1,
    HALT = 2'd2
  } state_t;

  state_t            cur, nxt;
  logic [CW-1:0]     cnt, cnt_nxt;
  logic              pending;
  logic [STAGES-1:0] occ, occ_shifted;
  logic              shift;
  logic              accept;
  logic              exit_piece;
  logic              z_q, reject_q;
  logic [CNT_W-1:0]  good_q, rej_q;

  assign accept      = bus.piece_in & ~pending;
  assign occ_shifted = {occ[STAGES-2:0], pending};
  assign exit_piece  = shift & occ[STAGES-1];

  always_comb begin
    nxt     = cur;
    cnt_nxt = cnt;
    shift   = 1'b0;
    case (cur)
      IDLE: begin
        if (pending && !bus.halt) begin
          shift   = 1'b1;
          cnt_nxt = '0;
          nxt     = WORK;
        end
      end
      WORK: begin
        // halt takes priority over the timer expiring on the same edge
        if (bus.halt) begin
          nxt = HALT;
        end else if (cnt != LAST) begin
          cnt_nxt = cnt + CW'(1);
        end else begin
          shift   = 1'b1;
          cnt_nxt = '0;
          nxt     = (occ_shifted == '0) ? IDLE : WORK;
        end
      end
      HALT: begin
        if (!bus.halt) nxt = WORK;
      end
      default: nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cur      <= IDLE;
      cnt      <= '0;
      pending  <= 1'b0;
      occ      <= '0;
      z_q      <= 1'b0;
      reject_q <= 1'b0;
      good_q   <= '0;
      rej_q    <= '0;
    end else begin
      cur <= nxt;
      cnt <= cnt_nxt;
      if (shift) occ <= occ_shifted;
      // accept needs pending=0, so it never collides with the shift clearing pending
      if (accept)     pending <= 1'b1;
      else if (shift) pending <= 1'b0;
      z_q      <= exit_piece & bus.qc_ok;
      reject_q <= exit_piece & ~bus.qc_ok;
      if (exit_piece && bus.qc_ok && good_q != CNT_MAX) good_q <= good_q + CNT_W'(1);
      if (exit_piece && !bus.qc_ok && rej_q != CNT_MAX) rej_q <= rej_q + CNT_W'(1);
    end
  end

  assign bus.piece_rdy    = ~pending;
  assign bus.z            = z_q;
  assign bus.reject       = reject_q;
  assign bus.occupancy    = occ;
  assign bus.good_count   = good_q;
  assign bus.reject_count = rej_q;
  assign state            = cur;
endmodule
